// File: rtl/print_uart_tx.sv
// print_uart_tx: buffers print-port bytes in a FIFO and serialises them as 8N1 UART, LSB first.
module print_uart_tx #(
  parameter int CLK_DIV    = 868,
  parameter int FIFO_DEPTH = 16,
  parameter int ADDR_W     = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              print_valid,
  input  logic [7:0]        print_value,
  input  logic              clr_overflow,
  output logic              uart_tx,
  output logic              busy,
  output logic [ADDR_W:0]   fifo_count,
  output logic              overflow
);
  localparam int CW = $clog2(CLK_DIV);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t            state_q, state_d;
  logic [CW-1:0]     baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        shift_q, shift_d;
  logic [7:0]        mem_q [FIFO_DEPTH];
  logic [ADDR_W-1:0] wptr_q, rptr_q;
  logic [ADDR_W:0]   count_q, count_d;
  logic              tx_q, tx_d, ovf_q, push, pop, bit_end, full, has_data;
  // Fullness is judged on the pre-edge count, so a same-edge pop never rescues a push.
  assign full     = count_q == (ADDR_W+1)'(FIFO_DEPTH);
  assign has_data = count_q != '0;
  assign push     = print_valid && !full;
  assign bit_end  = baud_q == CW'(CLK_DIV-1);
  always_comb begin
    state_d = state_q;
    baud_d  = bit_end ? '0 : baud_q + CW'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        baud_d  = '0;
        pop     = has_data;
        shift_d = has_data ? mem_q[rptr_q] : shift_q;
        state_d = has_data ? START : IDLE;
        tx_d    = !has_data;
      end
      START: if (bit_end) begin
        state_d = DATA;
        tx_d    = shift_q[0];
        bit_d   = '0;
      end
      DATA: if (bit_end) begin
        shift_d = shift_q >> 1;
        state_d = (bit_q == 3'd7) ? STOP : DATA;
        tx_d    = (bit_q == 3'd7) ? 1'b1 : shift_q[1];
        bit_d   = bit_q + 3'd1;
      end
      default: if (bit_end) begin
        pop     = has_data;
        shift_d = has_data ? mem_q[rptr_q] : shift_q;
        state_d = has_data ? START : IDLE;
        tx_d    = !has_data;
      end
    endcase
    count_d = (push && !pop) ? count_q + (ADDR_W+1)'(1) :
              (pop && !push) ? count_q - (ADDR_W+1)'(1) : count_q;
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      wptr_q  <= push ? wptr_q + ADDR_W'(1) : wptr_q;
      rptr_q  <= pop ? rptr_q + ADDR_W'(1) : rptr_q;
      count_q <= count_d;
      ovf_q   <= (print_valid && full) || (ovf_q && !clr_overflow);
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= print_value;
  end
  assign uart_tx    = tx_q;
  assign busy       = state_q != IDLE;
  assign fifo_count = count_q;
  assign overflow   = ovf_q;
endmodule

// File: doc/print_uart_tx.md
Name: print_uart_tx

Overview:
- Sits downstream of the core top's print port and consumes its print_valid/print_value byte stream.
- Buffers bytes in a small synchronous FIFO and serialises them onto a UART TX line, 8N1, LSB first.
- Lets firmware "print" at full core speed without stalling; bytes arriving when the buffer is full are dropped and flagged.

Parameters:
- CLK_DIV, 868, clock cycles per UART bit (100 MHz / 115200); legal range >= 2.
- FIFO_DEPTH, 16, FIFO entries; must be a power of 2.
- ADDR_W, 4, log2(FIFO_DEPTH).

Ports:
- clk  in  1  single clock; all logic on rising edge.
- resetn  in  1  synchronous, active-low reset.
- print_valid  in  1  one-cycle strobe: print_value holds a byte to send.
- print_value  in  8  byte to transmit.
- clr_overflow  in  1  one-cycle strobe clearing the overflow flag.
- uart_tx  out  1  serial output; idles high.
- busy  out  1  high whenever the TX FSM is not in IDLE.
- fifo_count  out  ADDR_W+1  current FIFO occupancy, 0..FIFO_DEPTH.
- overflow  out  1  sticky flag: at least one byte was dropped.

Behaviour:
- Reset (resetn low at a rising edge):
  - uart_tx=1, busy=0, fifo_count=0, overflow=0.
  - FSM goes to IDLE; read/write pointers and bit/baud counters go to 0.
  - Applies mid-frame too: the line returns high at that edge and the partial byte and all buffered bytes are discarded.
- FIFO write:
  - At an edge with print_valid=1 and pre-edge count < FIFO_DEPTH, the byte is stored and the write pointer increments modulo FIFO_DEPTH.
  - If pre-edge count == FIFO_DEPTH, the byte is dropped and overflow is set, even if a pop occurs at the same edge. "Full" is judged on the pre-edge count only.
- FIFO pop: only the FSM pops (see transitions). A same-edge push and pop leaves the count unchanged.
- overflow: a set and a clr_overflow at the same edge leave overflow=1 (set wins).
- FSM states: IDLE, START, DATA, STOP.
  - Baud counter counts 0..CLK_DIV-1. A "bit end" is the edge where it equals CLK_DIV-1; the counter then wraps to 0.
- FSM transitions:
  - IDLE: if pre-edge count > 0, pop the head into the shift register, go to START, uart_tx=0, baud counter=0. Otherwise stay, uart_tx=1.
  - START: at bit end, go to DATA, uart_tx=shift[0], bit index=0.
  - DATA: at each bit end, shift right. After bit index 7 completes, go to STOP with uart_tx=1. Otherwise bit index +1 and uart_tx shows the next bit.
  - STOP: at bit end, if pre-edge count > 0, pop and go directly to START with uart_tx=0 (no idle gap). Otherwise go to IDLE.
- Timing:
  - Each frame is exactly 10*CLK_DIV cycles; back-to-back frames are contiguous.
  - Latency: a byte written at edge N into an empty FIFO with FSM in IDLE is popped at edge N+1, so uart_tx falls at edge N+1.
- busy = (state != IDLE), registered with the state.
- print_value is ignored when print_valid=0.
- Counters are widened so that CLK_DIV-1 fits; no other arithmetic.

Test Plan (CLK_DIV=4, FIFO_DEPTH=16 unless stated):
- Reset, then single print_valid with 0x55 at edge 0:
  - uart_tx=0 on cycles 1-4.
  - Then 1,0,1,0,1,0,1,0 for 4 cycles each (cycles 5-36).
  - Then 1 for the stop bit (cycles 37-40).
  - busy falls at edge 41; fifo_count is 1 after edge 0 and 0 after edge 1.
- Bytes 0xA0, 0x0F written on consecutive edges 0 and 1:
  - Second START begins at edge 41 with no idle cycle.
  - busy stays 1 from edge 1 through edge 80.
  - Decoded line gives A0 then 0F.
- Burst of 20 bytes (0x00..0x13) on edges 0..19:
  - 0x00 popped at edge 1; fifo_count reaches 16 at edge 16.
  - Bytes 0x11-0x13 are dropped and overflow=1.
  - Line carries exactly 0x00..0x10 in order, and fifo_count returns to 0.
- Overflow set and clr_overflow asserted on the same edge: overflow remains 1. clr_overflow alone on a later edge: overflow becomes 0.
- resetn low for one edge during the DATA state of byte 0x3C with 5 bytes queued: at that edge uart_tx=1, busy=0, fifo_count=0, and no further frames appear.
- CLK_DIV=2, byte 0xFF: START is 2 cycles low, then 18 cycles high (8 data bits plus stop). Total frame length is 20 cycles.
